noc_data_collector: RTL

- Sits directly downstream of the per-node NoC output register stage and consumes its per-node valid/data/off signals.
- Buffers each node's words in a private FIFO.
- Merges all nodes into one node-tagged output stream using round-robin arbitration and a valid/ready handshake.
- Returns per-node almost-full flags and sticky overflow flags.

---
 rtl/noc_data_collector.sv | 128 ++++++++++++
 1 files changed

// File: rtl/noc_data_collector.sv
// Per-node FIFO buffering of NoC output words, merged into one node-tagged stream
// by a round-robin arbiter feeding a valid/ready output register.
module noc_data_collector #(
    parameter int DATA_W       = 8,
    parameter int NODE_PER_ROW = 4,
    parameter int NODE_PER_COL = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int N           = NODE_PER_ROW * NODE_PER_COL,
    localparam int ID_W        = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          valid_i,
    input  logic [N*DATA_W-1:0]   data_i,
    input  logic [N-1:0]          off_sigs_i,
    output logic [N-1:0]          almost_full_o,
    output logic [N-1:0]          overflow_o,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [ID_W-1:0]       out_node_id
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N - 1);

    logic [DATA_W-1:0] mem    [N][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [N];
    logic [PTR_W-1:0]  rd_ptr [N];
    logic [CNT_W-1:0]  count  [N];

    logic [N-1:0]      eligible;
    logic [N-1:0]      push;
    logic [N-1:0]      pop;
    logic [N-1:0]      drop;
    logic [ID_W-1:0]   rr;
    logic [ID_W-1:0]   grant;
    logic              found;
    logic              load_en;
    logic [DATA_W-1:0] head_data;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return ID_W'(s);
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            eligible[k]      = (count[k] != '0) && !off_sigs_i[k];
            almost_full_o[k] = (count[k] >= AF_LVL);
        end
    end

    // First eligible node at or after the rr pointer wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && eligible[wrap_add(rr, i)]) begin
                grant = wrap_add(rr, i);
                found = 1'b1;
            end
        end
    end

    assign load_en   = (!out_valid || out_ready) && found;
    assign head_data = mem[grant][rd_ptr[grant]];

    // A full FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            pop[k]  = load_en && (grant == ID_W'(k));
            push[k] = valid_i[k] && ((count[k] != FULL_LVL) || pop[k]);
            drop[k] = valid_i[k] && (count[k] == FULL_LVL) && !pop[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (push[k]) mem[k][wr_ptr[k]] <= data_i[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
            overflow_o <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
                if (push[k] && !pop[k])      count[k] <= count[k] + CNT_ONE;
                else if (!push[k] && pop[k]) count[k] <= count[k] - CNT_ONE;
                if (drop[k]) overflow_o[k] <= 1'b1;
            end
        end
    end

    // Output register stage: load on grant, otherwise hold or retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr          <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_node_id <= '0;
        end else if (load_en) begin
            rr          <= (grant == ID_LAST) ? '0 : grant + ID_ONE;
            out_valid   <= 1'b1;
            out_data    <= head_data;
            out_node_id <= grant;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
